mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory-stage load/store unit fed by the E/M pipeline register, consuming its ALUResult_m, WriteData_m, MemWrite_m and ResultSrc_m outputs.
//  Runs a req/gnt/rvalid transaction on the data bus, forms byte enables and store data, and sign/zero-extends load data.
//  Drives ReadData_m to the M/W register. Asserts stall_m to the hazard unit while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles req may wait for gnt before abort (>=1)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   reset, synchronous, active-low
//  ALUResult_m  in   32  effective byte address
//  WriteData_m  in   32  store data (rs2), unaligned in low bits
//  funct3_m     in   3   access size/sign (RV32I load/store funct3)
//  MemWrite_m   in   1   store in M stage
//  ResultSrc_m  in   2   2'b01 = load in M stage
//  hold_m       in   1   downstream (M/W) stall; M instruction must not retire
//  ReadData_m   out  32  extended load result, valid while state==DONE
//  stall_m      out  1   M stage busy; freeze PC, F/D, D/E, E/M
//  misalign_m   out  1   1-cycle pulse: misaligned access, no bus traffic
//  bus_err_m    out  1   1-cycle pulse: gnt timeout
//  dmem_req     out  1   bus request
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word address {ALUResult_m[31:2],2'b00}
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-aligned store data
//  dmem_gnt     in   1   request accepted this cycle
//  dmem_rvalid  in   1   response (load data or store ack), >=1 cycle after gnt
//  dmem_rdata   in   32  load word
// BEHAVIOUR
//  access = MemWrite_m | (ResultSrc_m==2'b01); misaligned = (size H & a[0]) | (size W & a[1:0]!=0).
//  FSM states IDLE, REQ, WAIT, DONE; reset -> IDLE, all outputs 0, timeout counter 0.
//  IDLE: access & !misaligned -> REQ. access & misaligned -> misalign_m=1 same cycle, stay IDLE, no stall.
//  REQ: dmem_req=1 with addr/we/be/wdata from current inputs; gnt -> WAIT; counter==TIMEOUT_CYCLES-1 & !gnt -> bus_err_m pulse, DONE, ReadData_m=0.
//  WAIT: req=0; on rvalid, capture extended dmem_rdata into ReadData_m -> DONE. rvalid always follows gnt.
//  DONE: stall_m=0 so the pipeline advances. hold_m=1 -> stay DONE, ReadData_m held. hold_m=0 -> IDLE.
//  stall_m = access & !misaligned & (state IDLE|REQ|WAIT); combinational, asserted in the IDLE cycle the access arrives.
//  Minimum latency: IDLE->REQ(gnt)->WAIT(rvalid)->DONE = 3 cycles when gnt and rvalid occur in the earliest cycles.
//  Timeout counter clears on leaving REQ. A late gnt after timeout is ignored: req is already 0.
//  be/wdata: SB be=1<<a[1:0], wdata={4{rs2[7:0]}}; SH be=a[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111.
//  Loads: select lane by a[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW pass through. Loads drive be per size.
//  Undefined funct3 (011,110,111) is treated as W.
//  Back-to-back accesses: after DONE->IDLE, the next instruction's access starts REQ the following cycle.
//  Reset mid-transaction: IDLE next edge, req drops immediately. The bus side must tolerate the abandoned request.
// TESTING
//  LW a=0x100, gnt cycle1, rvalid cycle2, rdata=0xDEADBEEF -> ReadData_m=0xDEADBEEF in DONE; stall_m high 3 cycles.
//  LB a=0x103, rdata=0x80xxxxxx -> ReadData_m=0xFFFFFF80; LBU -> 0x00000080; LHU a=0x102, rdata=0x8001xxxx -> 0x00008001.
//  SB a=0x201, rs2=0x000000AB -> be=0010, wdata=0xABABABAB, we=1; SH a=0x202 -> be=1100.
//  LW a=0x102 -> misalign_m pulse, dmem_req never high, stall_m=0.
//  gnt held low, TIMEOUT_CYCLES=4 -> req high 4 cycles, bus_err_m pulse, ReadData_m=0, stall released.
//  hold_m=1 for 3 cycles in DONE -> ReadData_m stable; rst_n=0 during WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one req/gnt/rvalid data-bus transaction per
// M-stage access, forms byte lanes for stores, and extends load data for M/W.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResult_m,
  input  logic [31:0] WriteData_m,
  input  logic [2:0]  funct3_m,
  input  logic        MemWrite_m,
  input  logic [1:0]  ResultSrc_m,
  input  logic        hold_m,
  output logic [31:0] ReadData_m,
  output logic        stall_m,
  output logic        misalign_m,
  output logic        bus_err_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              access, misaligned, size_b, size_h, timeout;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;

  // Lane select plus sign/zero extension; undefined funct3 falls through as a word.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [2:0] f3);
    logic [DATA_W-1:0] shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    shifted = word >> {lane, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      3'b000:  extend_load = DATA_W'(byte_s);
      3'b100:  extend_load = {24'b0, shifted[7:0]};
      3'b001:  extend_load = DATA_W'(half_s);
      3'b101:  extend_load = {16'b0, shifted[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  assign access     = MemWrite_m | (ResultSrc_m == 2'b01);
  assign size_b     = (funct3_m[1:0] == 2'b00);
  assign size_h     = (funct3_m[1:0] == 2'b01);
  assign misaligned = (size_h & ALUResult_m[0]) | (!size_b & !size_h & (|ALUResult_m[1:0]));
  assign timeout    = (state == S_REQ) & !dmem_gnt & (tmo_cnt == CNT_LAST);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteData_m;
    if (size_b) begin
      be_c    = 4'b0001 << ALUResult_m[1:0];
      wdata_c = {4{WriteData_m[7:0]}};
    end else if (size_h) begin
      be_c    = ALUResult_m[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{WriteData_m[15:0]}};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (access && !misaligned) state_nxt = S_REQ;
      S_REQ: begin
        if (dmem_gnt)     state_nxt = S_WAIT;
        else if (timeout) state_nxt = S_DONE;
      end
      S_WAIT: if (dmem_rvalid) state_nxt = S_WAIT == state ? S_DONE : state;
      S_DONE: if (!hold_m) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant timeout counter: counts ungranted REQ cycles, clears whenever REQ is left
  always_ff @(posedge clk) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state == S_REQ && !dmem_gnt && !timeout)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end

  // Load result register; only visible while DONE, so it needs no reset
  always_ff @(posedge clk) begin
    if (state == S_WAIT && dmem_rvalid)
      rdata_q <= extend_load(dmem_rdata, ALUResult_m[1:0], funct3_m);
    else if (timeout)
      rdata_q <= '0;
  end

  // Outputs are forced low while rst_n is asserted so an abandoned request drops at once
  always_comb begin
    stall_m    = rst_n & access & !misaligned & (state != S_DONE);
    misalign_m = rst_n & (state == S_IDLE) & access & misaligned;
    bus_err_m  = rst_n & timeout;
    dmem_req   = rst_n & (state == S_REQ);
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    ReadData_m = '0;
    if (dmem_req) begin
      dmem_we    = MemWrite_m;
      dmem_addr  = {ALUResult_m[31:2], 2'b00};
      dmem_be    = be_c;
      dmem_wdata = wdata_c;
    end
    if (rst_n && state == S_DONE)
      ReadData_m = rdata_q;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: table of directed transactions, reset/timeout sequences,
// and random transactions checked against an arithmetic reference model.
module tb_mem_stage_lsu;
  localparam int TMO = 4;

  logic        clk, rst_n;
  logic [31:0] ALUResult_m, WriteData_m;
  logic [2:0]  funct3_m;
  logic        MemWrite_m;
  logic [1:0]  ResultSrc_m;
  logic        hold_m;
  logic [31:0] ReadData_m;
  logic        stall_m, misalign_m, bus_err_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;

  int total = 0;
  int bad   = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m), .funct3_m(funct3_m),
    .MemWrite_m(MemWrite_m), .ResultSrc_m(ResultSrc_m), .hold_m(hold_m),
    .ReadData_m(ReadData_m), .stall_m(stall_m), .misalign_m(misalign_m),
    .bus_err_m(bus_err_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes and arithmetic lane rules
  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % sz(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << sz(f3)) - 1) << int'(a[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] rs2);
    longint v, res;
    int s;
    s = sz(f3);
    v = longint'(rs2) & ((64'sd1 <<< (8 * s)) - 1);
    res = 0;
    for (int i = 0; i < 4 / s; i++) res = res | (v <<< (8 * s * i));
    return 32'(res);
  endfunction

  function automatic logic [31:0] ref_ld(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    longint v;
    int s;
    s = sz(f3);
    v = (longint'(rdata) >>> (8 * int'(a[1:0]))) & ((64'sd1 <<< (8 * s)) - 1);
    if (!f3[2] && s < 4 && v >= (64'sd1 <<< (8 * s - 1))) v = v - (64'sd1 <<< (8 * s));
    return 32'(v);
  endfunction

  // One M-stage access: g = REQ cycles before gnt (>=TMO means never), r = WAIT cycles
  task automatic run_txn(input logic [2:0] f3, input logic [31:0] a, input logic st,
                         input logic [31:0] rs2, input int g, input int r,
                         input logic [31:0] rdata, input int h, input logic gap,
                         input logic exp_mis, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    logic tmo;
    ALUResult_m = a; WriteData_m = rs2; funct3_m = f3;
    MemWrite_m = st; ResultSrc_m = st ? 2'b00 : 2'b01;
    hold_m = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    chk("misalign_idle", misalign_m, exp_mis);
    chk("stall_idle", stall_m, !exp_mis);
    chk("req_idle", dmem_req, 1'b0);
    @(posedge clk); #1;
    if (exp_mis) begin
      MemWrite_m = 1'b0; ResultSrc_m = 2'b00;
      @(negedge clk);
      chk("mis_noreq", dmem_req, 1'b0);
      chk("mis_pulse_end", misalign_m, 1'b0);
      @(posedge clk); #1;
      return;
    end
    tmo = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      dmem_gnt = (k == g);
      @(negedge clk);
      chk("req", dmem_req, 1'b1);
      chk("we", dmem_we, st);
      chk("addr", dmem_addr, {a[31:2], 2'b00});
      chk("be", dmem_be, exp_be);
      if (st) chk("wdata", dmem_wdata, exp_wd);
      chk("stall_req", stall_m, 1'b1);
      tmo = (k == TMO - 1) && (k != g);
      chk("bus_err", bus_err_m, tmo);
      @(posedge clk); #1;
      if (k == g) break;
    end
    dmem_gnt = 1'b0;
    if (!tmo) begin
      for (int k = 0; k < r; k++) begin
        dmem_rvalid = (k == r - 1);
        dmem_rdata  = (k == r - 1) ? rdata : $urandom;
        @(negedge clk);
        chk("req_wait", dmem_req, 1'b0);
        chk("stall_wait", stall_m, 1'b1);
        @(posedge clk); #1;
      end
    end
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
    for (int k = 0; k <= h; k++) begin
      hold_m   = (k < h);
      dmem_gnt = tmo;
      @(negedge clk);
      chk("stall_done", stall_m, 1'b0);
      chk("req_done", dmem_req, 1'b0);
      chk("bus_err_done", bus_err_m, 1'b0);
      if (!st || tmo) chk("read_data", ReadData_m, exp_rd);
      @(posedge clk); #1;
    end
    hold_m = 1'b0; dmem_gnt = 1'b0;
    if (gap) begin
      MemWrite_m = 1'b0; ResultSrc_m = 2'b00;
      @(negedge clk);
      chk("idle_rd", ReadData_m, 32'h0);
      chk("idle_stall", stall_m, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic        st;
    logic [31:0] rs2;
    int          g;
    int          r;
    logic [31:0] rdata;
    int          h;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{3'b010, 32'h100, 1'b0, 32'h0,        0,  1, 32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{3'b000, 32'h103, 1'b0, 32'h0,        0,  1, 32'h80123456, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{3'b100, 32'h103, 1'b0, 32'h0,        1,  2, 32'h80123456, 0, 1'b0, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{3'b101, 32'h102, 1'b0, 32'h0,        0,  1, 32'h80011234, 1, 1'b0, 4'b1100, 32'h0,        32'h00008001};
    vecs[4]  = '{3'b001, 32'h102, 1'b0, 32'h0,        0,  1, 32'h80011234, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[5]  = '{3'b000, 32'h201, 1'b1, 32'h000000AB, 0,  1, 32'h0,        0, 1'b0, 4'b0010, 32'hABABABAB, 32'h0};
    vecs[6]  = '{3'b001, 32'h202, 1'b1, 32'h1234CAFE, 0,  1, 32'h0,        0, 1'b0, 4'b1100, 32'hCAFECAFE, 32'h0};
    vecs[7]  = '{3'b010, 32'h204, 1'b1, 32'h11223344, 2,  3, 32'h0,        0, 1'b0, 4'b1111, 32'h11223344, 32'h0};
    vecs[8]  = '{3'b010, 32'h102, 1'b0, 32'h0,        0,  1, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{3'b001, 32'h101, 1'b0, 32'h0,        0,  1, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{3'b011, 32'h300, 1'b0, 32'h0,        0,  1, 32'h89ABCDEF, 0, 1'b0, 4'b1111, 32'h0,        32'h89ABCDEF};
    vecs[11] = '{3'b010, 32'h400, 1'b0, 32'h0,        99, 1, 32'h0,        2, 1'b0, 4'b1111, 32'h0,        32'h0};
    vecs[12] = '{3'b001, 32'h100, 1'b0, 32'h0,        3,  2, 32'h00007FFF, 0, 1'b0, 4'b0011, 32'h0,        32'h00007FFF};
    vecs[13] = '{3'b000, 32'h100, 1'b0, 32'h0,        0,  1, 32'h000000FF, 3, 1'b0, 4'b0001, 32'h0,        32'hFFFFFFFF};
    vecs[14] = '{3'b110, 32'h108, 1'b0, 32'h0,        0,  1, 32'h12345678, 0, 1'b0, 4'b1111, 32'h0,        32'h12345678};
    vecs[15] = '{3'b000, 32'h102, 1'b0, 32'h0,        1,  1, 32'h00C30000, 0, 1'b0, 4'b0100, 32'h0,        32'hFFFFFFC3};
    vecs[16] = '{3'b000, 32'h203, 1'b1, 32'hFFFFFF5A, 0,  1, 32'h0,        0, 1'b0, 4'b1000, 32'h5A5A5A5A, 32'h0};

    // Reset with an access present: every output must stay low
    rst_n = 1'b0; hold_m = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    ALUResult_m = 32'h100; WriteData_m = 32'h0; funct3_m = 3'b010;
    MemWrite_m = 1'b0; ResultSrc_m = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_stall", stall_m, 1'b0);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_rd", ReadData_m, 32'h0);
      chk("rst_err", {misalign_m, bus_err_m}, 2'b00);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ResultSrc_m = 2'b00;

    for (int i = 0; i < 17; i++)
      run_txn(vecs[i].f3, vecs[i].a, vecs[i].st, vecs[i].rs2, vecs[i].g, vecs[i].r,
              vecs[i].rdata, vecs[i].h, 1'b1, vecs[i].mis, vecs[i].be, vecs[i].wd, vecs[i].rd);

    // Back-to-back: next access arrives right as DONE retires
    run_txn(3'b010, 32'h500, 1'b0, 32'h0, 0, 1, 32'hA5A5A5A5, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hA5A5A5A5);
    run_txn(3'b100, 32'h501, 1'b0, 32'h0, 0, 1, 32'h0000F700, 0, 1'b1, 1'b0, 4'b0010, 32'h0, 32'h000000F7);

    // Reset while WAITing: request abandoned, outputs low, late rvalid ignored
    ALUResult_m = 32'h600; funct3_m = 3'b010; MemWrite_m = 1'b0; ResultSrc_m = 2'b01;
    @(negedge clk); chk("rw_stall_idle", stall_m, 1'b1);
    @(posedge clk); #1; dmem_gnt = 1'b1;
    @(negedge clk); chk("rw_req", dmem_req, 1'b1);
    @(posedge clk); #1; dmem_gnt = 1'b0;
    @(negedge clk); chk("rw_wait_stall", stall_m, 1'b1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("rw_rst_req", dmem_req, 1'b0);
    chk("rw_rst_stall", stall_m, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; ResultSrc_m = 2'b00; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rw_idle_req", dmem_req, 1'b0);
    chk("rw_idle_stall", stall_m, 1'b0);
    chk("rw_idle_rd", ReadData_m, 32'h0);
    chk("rw_idle_err", {misalign_m, bus_err_m}, 2'b00);
    @(posedge clk); #1; dmem_rvalid = 1'b0;
    run_txn(3'b010, 32'h604, 1'b0, 32'h0, 0, 1, 32'hCAFEF00D, 0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D);

    // Random transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, rs2, rd;
      logic        st;
      st  = 1'($urandom_range(0, 1));
      f3  = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a   = 32'h1000 + 32'($urandom_range(0, 255));
      rs2 = $urandom;
      rd  = $urandom;
      begin
        int g;
        int r;
        g = $urandom_range(0, 5);
        r = $urandom_range(1, 3);
        run_txn(f3, a, st, rs2, g, r, rd, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                ref_mis(f3, a), ref_be(f3, a), ref_wd(f3, rs2),
                (g >= TMO) ? 32'h0 : ref_ld(f3, a, rd));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
